inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 105 ++++++++++
 tb/tb_inst_fetch.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: sync ROM read, two-edge latency to decode, stall/flush handling.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned redirect halts fetch and sets a sticky error.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_read_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        misalign_err
);
    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        err_q, err_d;

    logic [31:0] tgt;
    logic        bad_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt     = flush_pc;
    assign bad_tgt = flush && (flush_pc[1:0] != 2'b00);
`else
    // Low bits of the redirect target are ignored entirely.
    logic unused_lsb;
    assign unused_lsb = ^flush_pc[1:0];
    assign tgt        = {flush_pc[31:2], 2'b00};
    assign bad_tgt    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        err_d        = err_q;
        rom_en       = (state_q == S_RUN) && !rst && !bad_tgt;
        // On stall the in-flight address is re-read so ROM data stays paired with resp_pc_q.
        rom_addr     = flush ? tgt : (stall ? resp_pc_q : pc_q);

        if (state_q == S_HALT) begin
            id_valid_d = 1'b0;
        end else if (flush) begin
            id_valid_d = 1'b0;
            if (bad_tgt) begin
                err_d   = 1'b1;
                state_d = S_HALT;
            end else begin
                resp_pc_d    = tgt;
                resp_valid_d = 1'b1;
                pc_d         = tgt + 32'd4;
            end
        end else if (!stall) begin
            pc_d         = pc_q + 32'd4;
            resp_pc_d    = pc_q;
            resp_valid_d = 1'b1;
            id_valid_d   = resp_valid_q;
            id_pc_d      = resp_pc_q;
            id_inst_d    = rom_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= 32'd0;
            id_inst_q    <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_inst_q    <= id_inst_d;
            err_q        <= err_d;
        end
    end

    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_inst      = id_inst_q;
    assign misalign_err = err_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: synchronous ROM model, queue-based stream model, directed + random steps.
module tb_inst_fetch;
    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, flush = 1'b0;
    logic [31:0] flush_pc = 32'd0;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_read_data = 32'd0;
    logic        id_valid;
    logic [31:0] id_pc, id_inst;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    // Reference state: fetch stream as "next address" plus a queue of issued-not-delivered addresses.
    logic [31:0] m_next;
    logic [31:0] pend[$];
    logic        m_vld, m_halt, m_err, m_zero;
    logic [31:0] m_pc;

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_read_data(rom_read_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == RPC)          return 32'h2408_FFFF;
        if (a == RPC + 32'd4)  return 32'h2409_0002;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk) if (rom_en) rom_read_data <= rom_word(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] fp);
        logic [31:0] fe;
        logic        bad;
        @(negedge clk);
        rst = r; stall = s; flush = f; flush_pc = fp;
`ifdef FETCH_ALIGN_CHECK_EN
        fe  = fp;
        bad = f && (fp[1:0] != 2'b00);
`else
        fe  = {fp[31:2], 2'b00};
        bad = 1'b0;
`endif
        #1;
        chk("rom_en", {31'd0, rom_en}, {31'd0, !r && !m_halt && !bad});
        @(posedge clk);
        m_zero = 1'b0;
        if (r) begin
            m_next = RPC; pend.delete(); m_vld = 0; m_halt = 0; m_err = 0; m_zero = 1'b1;
        end else if (m_halt) begin
            m_vld = 0;
        end else if (f) begin
            m_vld = 0;
            if (bad) begin
                m_halt = 1; m_err = 1;
            end else begin
                pend.delete(); pend.push_back(fe); m_next = fe + 32'd4;
            end
        end else if (!s) begin
            if (pend.size() > 0) begin
                m_vld = 1; m_pc = pend.pop_front();
            end else m_vld = 0;
            pend.push_back(m_next);
            m_next = m_next + 32'd4;
        end
        #1;
        chk("id_valid", {31'd0, id_valid}, {31'd0, m_vld});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
        if (m_vld) begin
            chk("id_pc", id_pc, m_pc);
            chk("id_inst", id_inst, rom_word(m_pc));
        end
        if (m_zero) begin
            chk("rst_id_pc", id_pc, 32'd0);
            chk("rst_id_inst", id_inst, 32'd0);
        end
    endtask

    initial begin
        m_next = RPC; m_vld = 0; m_halt = 0; m_err = 0; m_zero = 0; m_pc = 0;
        // Reset, then straight-line fetch: RPC on second edge, RPC+4 on third.
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); chk("first_pc", id_pc, RPC); chk("first_inst", id_inst, 32'h2408_FFFF);
        step(0, 0, 0, 0); chk("second_pc", id_pc, RPC + 32'd4); chk("second_inst", id_inst, 32'h2409_0002);
        // Three-cycle stall freezes id_* at RPC+4, then RPC+8 follows.
        repeat (3) begin step(0, 1, 0, 0); chk("stall_hold", id_pc, RPC + 32'd4); end
        step(0, 0, 0, 0); chk("after_stall", id_pc, RPC + 32'd8);
        // Flush concurrent with stall.
        step(0, 1, 1, RPC + 32'd16); chk("flush_bubble", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 0); chk("flush_tgt", id_pc, RPC + 32'd16);
        step(0, 0, 0, 0); chk("flush_next", id_pc, RPC + 32'd20);
        // Address wrap.
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0); chk("wrap_a", id_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0); chk("wrap_b", id_pc, 32'h0000_0000);
        // One-cycle reset mid-stream with stall high.
        step(1, 1, 0, 0); chk("rst_mid", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); chk("rst_resume", id_pc, RPC);
        // Misaligned redirect.
        step(0, 0, 1, RPC + 32'd2);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
        chk("misalign_halt", {31'd0, id_valid}, 32'd0);
        step(0, 0, 1, RPC + 32'd8); chk("halt_ignores_flush", {31'd0, id_valid}, 32'd0);
        step(1, 0, 0, 0); chk("misalign_clear", {31'd0, misalign_err}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); chk("halt_resume", id_pc, RPC);
`else
        chk("misalign_masked", id_pc, RPC);
        chk("misalign_none", {31'd0, misalign_err}, 32'd0);
`endif
        // Randomized traffic against the stream model.
        for (int i = 0; i < 400; i++) begin
            logic r, s, f;
            logic [31:0] fp;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 30);
            f  = ($urandom_range(0, 99) < 6);
            fp = $urandom;
            if ($urandom_range(0, 9) != 0) fp[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) fp = 32'hFFFF_FFF8;
            step(r, s, f, fp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
